divider: RTL
============

Name: divider

Overview:
- Sequential restoring divider, the inverse of the team's shift-add multiplier.
- Accepts a 2*WIDTH-bit dividend and a WIDTH-bit divisor, and produces a 2*WIDTH-bit quotient and a WIDTH-bit remainder, one quotient bit per clock.
- Implemented as a controller FSM plus a datapath in one module; it shares the multiplier's start/done handshake, so a bench can round-trip multiplier results through it.

Parameters:
- WIDTH, 7, divisor and remainder width. Dividend and quotient are 2*WIDTH bits.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a division; sampled on the rising edge
- dividend  input  2*WIDTH  numerator; captured when start is accepted
- divisor  input  WIDTH  denominator; captured when start is accepted
- quotient  output  2*WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse marking a valid result
- div_zero  output  1  divide-by-zero flag; meaningful only with DIVIDER_DIV_ZERO_EN, tied 0 otherwise

Behaviour:
- Reset (synchronous, active-high, clock and reset only):
  - State goes to IDLE.
  - quotient, remainder, busy, done and div_zero all go to 0.
  - Internal counter and working registers are cleared.
  - Reset has priority over everything, including mid-RUN; an aborted operation produces no done.
- States:
  - IDLE: busy=0, done=0. start=1 captures dividend and divisor, clears the partial remainder (WIDTH+1 bits) and loads the counter with 2*WIDTH. Next state is RUN.
  - RUN: busy=1. Each edge performs one iteration:
    - shift {partial remainder, dividend shift register} left by 1;
    - trial = partial remainder - divisor, at WIDTH+1 bits;
    - if trial is non-negative, partial remainder = trial and the quotient LSB is 1; otherwise the remainder is restored and the quotient LSB is 0;
    - the counter decrements.
  - RUN ends on the edge where the counter reaches 0: quotient and remainder output registers load, done=1, next state is DONE.
  - DONE: busy=0. done drops to 0 after one cycle. start=1 here behaves as in IDLE and goes directly to RUN; otherwise next state is IDLE.
- Latency:
  - Let E0 be the edge that samples start. Iterations occur on E1 through E(2*WIDTH).
  - done is high in the cycle following E(2*WIDTH), i.e. for the default WIDTH, 14 edges after E0.
  - Throughput is one result per 2*WIDTH+1 cycles.
- Outputs:
  - quotient and remainder stay at their previous values throughout RUN.
  - They update only on the completing edge and then hold until the next completion or reset.
- start while busy=1 is ignored: no restart and no operand capture.
- Dividend and divisor may change freely after E0.
- Arithmetic:
  - Unsigned. The invariant dividend = quotient*divisor + remainder holds, with remainder < divisor.
  - Quotient cannot overflow because it is 2*WIDTH bits wide.
  - The partial remainder is WIDTH+1 bits so the trial subtraction never wraps.
- Divisor = 0 without the macro: the divide runs the full 2*WIDTH iterations. Result is quotient = all ones, remainder = dividend[WIDTH-1:0], and div_zero = 0.

Optional Feature:
- DIVIDER_DIV_ZERO_EN defined:
  - start with divisor = 0 skips RUN: on E0 the FSM goes directly to DONE.
  - In the next cycle, done=1 and div_zero=1, quotient is all ones, and remainder = dividend[WIDTH-1:0].
  - div_zero clears on the next accepted start or on reset.
  - Nonzero divisors run with normal timing and div_zero=0.
- DIVIDER_DIV_ZERO_EN undefined:
  - The div_zero port remains present and tied to 0.
  - Divisor = 0 takes the full-length path described above.

Test Plan:
- Reset, then dividend=100, divisor=7 with a single start pulse -> busy high for 14 cycles; done pulses once 14 edges after E0 with quotient=14, remainder=2; busy=0 afterwards and outputs hold.
- dividend=16383, divisor=127 -> quotient=129, remainder=0. dividend=5, divisor=9 -> quotient=0, remainder=5. dividend=0, divisor=1 -> quotient=0, remainder=0.
- Start 100/7, pulse start again with 50/5 at E5 -> second start ignored; the result is still 14 r 2. Then pulse start in the DONE cycle with 50/5 -> back-to-back run gives quotient=10, remainder=0.
- Start 100/7, assert reset at E6 -> all outputs 0, no done pulse. Then start 81/9 -> quotient=9, remainder=0.
- dividend=200, divisor=0:
  - without the macro -> done after 14 cycles, quotient=16383, remainder=72, div_zero=0;
  - with the macro -> done one cycle after E0, div_zero=1, same quotient and remainder values.
- Randomized sweep of 1000 operands, checked against the multiplier, i.e. quotient*divisor + remainder == dividend with remainder < divisor.

Source files
------------

// File: rtl/divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Define DIVIDER_DIV_ZERO_EN to short-circuit a zero divisor and raise div_zero.
module divider #(
    parameter int WIDTH = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 busy,
    output logic                 done,
    output logic                 div_zero
);

    localparam int CW = $clog2(2*WIDTH+1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    state_t             next_state;
    logic [WIDTH:0]     part_rem;
    logic [WIDTH+1:0]   shifted;
    logic [WIDTH+1:0]   trial;
    logic [WIDTH:0]     rem_next;
    logic [2*WIDTH-1:0] work;
    logic [2*WIDTH-1:0] work_next;
    logic [WIDTH-1:0]   divisor_reg;
    logic [CW-1:0]      count;
    logic               accept;
    logic               last_iter;
    logic               q_bit;
    logic               zero_skip;

    assign accept    = start && (state != RUN);
    assign last_iter = (count == CW'(1));
    assign busy      = (state == RUN);

`ifdef DIVIDER_DIV_ZERO_EN
    assign zero_skip = accept && (divisor == '0);
`else
    assign zero_skip = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, DONE: begin
                if (zero_skip)   next_state = DONE;
                else if (accept) next_state = RUN;
                else             next_state = IDLE;
            end
            RUN:     if (last_iter) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // One extra guard bit on the trial so its sign bit alone decides restore vs. keep.
    always_comb begin
        shifted   = {part_rem, work[2*WIDTH-1]};
        trial     = shifted - {2'b00, divisor_reg};
        q_bit     = ~trial[WIDTH+1];
        rem_next  = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
        work_next = {work[2*WIDTH-2:0], q_bit};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            part_rem    <= '0;
            work        <= '0;
            divisor_reg <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == RUN) begin
                part_rem <= rem_next;
                work     <= work_next;
                count    <= count - 1'b1;
                if (last_iter) begin
                    quotient  <= work_next;
                    remainder <= rem_next[WIDTH-1:0];
                    done      <= 1'b1;
                end
            end else if (start) begin
                divisor_reg <= divisor;
                work        <= dividend;
                part_rem    <= '0;
                count       <= CW'(2*WIDTH);
                if (zero_skip) begin
                    quotient  <= '1;
                    remainder <= dividend[WIDTH-1:0];
                    done      <= 1'b1;
                end
            end
        end
    end

`ifdef DIVIDER_DIV_ZERO_EN
    always_ff @(posedge clock) begin
        if (reset)       div_zero <= 1'b0;
        else if (accept) div_zero <= zero_skip;
    end
`else
    assign div_zero = 1'b0;
`endif

endmodule
